// File: rtl/oc8051_wb_mem_slave_if.sv
// ----------------------------------------------------------------------------
// oc8051_wb_mem_slave_if
//
// Bundles the two Wishbone channels of the oc8051 core plus the program-memory
// load port into one connection.
//
//   wbi_*  : instruction fetch channel (16-bit byte address, 32-bit read data)
//   wbd_*  : data channel (16-bit byte address, 8-bit read/write data)
//   ld_*   : side port used to preload program memory
//
// Modports:
//   master : the oc8051 core / testbench side, drives requests and load port
//   slave  : the memory responder side, drives data, ack and err
// ----------------------------------------------------------------------------
interface oc8051_wb_mem_slave_if;
  // instruction channel
  logic [15:0] wbi_adr_i;
  logic        wbi_stb_i;
  logic        wbi_cyc_i;
  logic [31:0] wbi_dat_o;
  logic        wbi_ack_o;
  logic        wbi_err_o;

  // data channel
  logic [15:0] wbd_adr_i;
  logic [7:0]  wbd_dat_i;
  logic        wbd_we_i;
  logic        wbd_stb_i;
  logic        wbd_cyc_i;
  logic [7:0]  wbd_dat_o;
  logic        wbd_ack_o;
  logic        wbd_err_o;

  // program-memory load port
  logic        ld_we_i;
  logic [15:0] ld_adr_i;
  logic [7:0]  ld_dat_i;

  modport master (
    output wbi_adr_i, wbi_stb_i, wbi_cyc_i,
    input  wbi_dat_o, wbi_ack_o, wbi_err_o,
    output wbd_adr_i, wbd_dat_i, wbd_we_i, wbd_stb_i, wbd_cyc_i,
    input  wbd_dat_o, wbd_ack_o, wbd_err_o,
    output ld_we_i, ld_adr_i, ld_dat_i
  );

  modport slave (
    input  wbi_adr_i, wbi_stb_i, wbi_cyc_i,
    output wbi_dat_o, wbi_ack_o, wbi_err_o,
    input  wbd_adr_i, wbd_dat_i, wbd_we_i, wbd_stb_i, wbd_cyc_i,
    output wbd_dat_o, wbd_ack_o, wbd_err_o,
    input  ld_we_i, ld_adr_i, ld_dat_i
  );
endinterface

// File: rtl/oc8051_wb_mem_slave.sv
// ----------------------------------------------------------------------------
// oc8051_wb_mem_slave
//
// Memory-side Wishbone responder for the oc8051 core. Serves 32-bit
// instruction fetches from a byte-wide program memory and 8-bit data
// reads/writes from a byte-wide data RAM. Each channel runs its own
// IDLE/WAIT/RESP state machine with a programmable number of wait states;
// accesses beyond the memory size are answered with err instead of ack.
//
// Ports:
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset (memories keep their contents)
//   bus      : oc8051_wb_mem_slave_if.slave (wbi_*, wbd_*, ld_* signals)
//
// Parameters:
//   IMEM_DEPTH : program memory size in bytes
//   DMEM_DEPTH : data RAM size in bytes
//   I_WAIT     : wait cycles before an instruction ack (0..15)
//   D_WAIT     : wait cycles before a data ack (0..15)
//
// Program memory is split into four byte banks (bank = address[1:0]) so that
// a fetch at any alignment reads its four bytes in one cycle, one from each
// bank, while every bank stays a simple single-read-port RAM.
// ----------------------------------------------------------------------------
module oc8051_wb_mem_slave #(
  parameter int IMEM_DEPTH = 4096,
  parameter int DMEM_DEPTH = 4096,
  parameter int I_WAIT     = 0,
  parameter int D_WAIT     = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  oc8051_wb_mem_slave_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] I_WAIT_C = 4'(I_WAIT);
  localparam logic [3:0] D_WAIT_C = 4'(D_WAIT);

  localparam int IB_DEPTH = (IMEM_DEPTH + 3) / 4;
  localparam int IB_AW    = (IB_DEPTH > 1) ? $clog2(IB_DEPTH) : 1;
  localparam int D_AW     = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);

  genvar gi;

  // ==========================================================================
  // Instruction channel
  // ==========================================================================
  logic [1:0]  i_state_reg, i_state_next;
  logic [3:0]  i_cnt_reg,   i_cnt_next;
  logic [15:0] i_adr_reg,   i_adr_next;
  logic        i_req;
  logic        i_go;          // this edge moves the channel into RESP
  logic [15:0] i_eff_adr;     // address of the access entering RESP
  logic        i_oor;
  logic [3:0]  i_byte_ok;     // per fetched byte: index lies inside IMEM
  logic        i_ack_reg;
  logic        i_err_reg;
  logic [1:0]  i_off_reg;
  logic [3:0]  i_ok_reg;
  logic [7:0]  bank_q [4];

  assign i_req = bus.wbi_cyc_i & bus.wbi_stb_i;

  always_comb begin
    i_state_next = i_state_reg;
    i_cnt_next   = i_cnt_reg;
    i_adr_next   = i_adr_reg;
    i_go         = 1'b0;
    case (i_state_reg)
      ST_IDLE: begin
        if (i_req) begin
          i_adr_next = bus.wbi_adr_i;
          i_cnt_next = I_WAIT_C;
          if (I_WAIT_C == 4'd0) begin
            i_state_next = ST_RESP;
            i_go         = 1'b1;
          end else begin
            i_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // a dropped request abandons the access silently
        if (!i_req) begin
          i_state_next = ST_IDLE;
        end else if (i_cnt_reg == 4'd1) begin
          i_state_next = ST_RESP;
          i_go         = 1'b1;
        end else begin
          i_cnt_next = i_cnt_reg - 4'd1;
        end
      end
      ST_RESP: i_state_next = ST_IDLE;
      default: i_state_next = ST_IDLE;
    endcase
    if (wb_rst_i) begin
      i_go = 1'b0;
    end
  end

  // With zero wait states the access enters RESP straight from IDLE, so the
  // RAM must be addressed from the bus rather than from the latch.
  assign i_eff_adr = (i_state_reg == ST_IDLE) ? bus.wbi_adr_i : i_adr_reg;
  assign i_oor     = ({1'b0, i_eff_adr} >= IMEM_LIM);

  // byte k of the word is m[a+k], computed in 17 bits so it never wraps
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_ok
      assign i_byte_ok[gi] = (({1'b0, i_eff_adr} + 17'(gi)) < IMEM_LIM);
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      i_state_reg <= ST_IDLE;
      i_cnt_reg   <= 4'd0;
      i_adr_reg   <= 16'd0;
      i_ack_reg   <= 1'b0;
      i_err_reg   <= 1'b0;
      i_off_reg   <= 2'd0;
      i_ok_reg    <= 4'd0;
    end else begin
      i_state_reg <= i_state_next;
      i_cnt_reg   <= i_cnt_next;
      i_adr_reg   <= i_adr_next;
      i_ack_reg   <= i_go & ~i_oor;
      i_err_reg   <= i_go & i_oor;
      if (i_go) begin
        i_off_reg <= i_eff_adr[1:0];
        i_ok_reg  <= i_byte_ok;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Program memory banks
  // --------------------------------------------------------------------------
  logic                 ld_ok;
  logic [IB_AW-1:0]     ld_idx;

  assign ld_ok  = ({1'b0, bus.ld_adr_i} < IMEM_LIM);
  assign ld_idx = IB_AW'(bus.ld_adr_i >> 2);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0]       mem [IB_DEPTH];
      logic [7:0]       q_reg;
      logic [1:0]       k;      // which byte of the word this bank supplies
      logic [16:0]      j;      // absolute byte index read from this bank
      logic [IB_AW-1:0] ridx;
      logic             ld_hit;

      assign k      = 2'(gi) - i_eff_adr[1:0];
      assign j      = {1'b0, i_eff_adr} + {15'd0, k};
      assign ridx   = IB_AW'(j >> 2);
      assign ld_hit = bus.ld_we_i & ld_ok & (bus.ld_adr_i[1:0] == 2'(gi));

      // Load and fetch in one block: a load to the byte being fetched on
      // the same edge leaves the fetch with the old contents.
      always_ff @(posedge wb_clk_i) begin
        if (ld_hit) begin
          mem[ld_idx] <= bus.ld_dat_i;
        end
        if (i_go) begin
          q_reg <= mem[ridx];
        end
      end

      assign bank_q[gi] = q_reg;
    end
  endgenerate

  // Reassemble the word little-endian; byte k came from bank (offset+k)%4.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [1:0] sel;
      assign sel = i_off_reg + 2'(gi);
      assign bus.wbi_dat_o[8*gi +: 8] = (i_ack_reg & i_ok_reg[gi]) ? bank_q[sel] : 8'h00;
    end
  endgenerate

  assign bus.wbi_ack_o = i_ack_reg;
  assign bus.wbi_err_o = i_err_reg;

  // ==========================================================================
  // Data channel
  // ==========================================================================
  logic [1:0]  d_state_reg, d_state_next;
  logic [3:0]  d_cnt_reg,   d_cnt_next;
  logic [15:0] d_adr_reg,   d_adr_next;
  logic [7:0]  d_dat_reg,   d_dat_next;
  logic        d_we_reg,    d_we_next;
  logic        d_req;
  logic        d_go;
  logic [15:0] d_eff_adr;
  logic [7:0]  d_eff_dat;
  logic        d_eff_we;
  logic        d_oor;
  logic [D_AW-1:0] d_idx;
  logic        d_ack_reg;
  logic        d_err_reg;
  logic        d_rd_reg;      // RESP of an in-range read: drive RAM data
  logic [7:0]  d_q_reg;
  logic [7:0]  dmem [DMEM_DEPTH];

  assign d_req = bus.wbd_cyc_i & bus.wbd_stb_i;

  always_comb begin
    d_state_next = d_state_reg;
    d_cnt_next   = d_cnt_reg;
    d_adr_next   = d_adr_reg;
    d_dat_next   = d_dat_reg;
    d_we_next    = d_we_reg;
    d_go         = 1'b0;
    case (d_state_reg)
      ST_IDLE: begin
        if (d_req) begin
          d_adr_next = bus.wbd_adr_i;
          d_dat_next = bus.wbd_dat_i;
          d_we_next  = bus.wbd_we_i;
          d_cnt_next = D_WAIT_C;
          if (D_WAIT_C == 4'd0) begin
            d_state_next = ST_RESP;
            d_go         = 1'b1;
          end else begin
            d_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!d_req) begin
          d_state_next = ST_IDLE;
        end else if (d_cnt_reg == 4'd1) begin
          d_state_next = ST_RESP;
          d_go         = 1'b1;
        end else begin
          d_cnt_next = d_cnt_reg - 4'd1;
        end
      end
      ST_RESP: d_state_next = ST_IDLE;
      default: d_state_next = ST_IDLE;
    endcase
    // reset drops a pending access, including its write
    if (wb_rst_i) begin
      d_go = 1'b0;
    end
  end

  assign d_eff_adr = (d_state_reg == ST_IDLE) ? bus.wbd_adr_i : d_adr_reg;
  assign d_eff_dat = (d_state_reg == ST_IDLE) ? bus.wbd_dat_i : d_dat_reg;
  assign d_eff_we  = (d_state_reg == ST_IDLE) ? bus.wbd_we_i  : d_we_reg;
  assign d_oor     = ({1'b0, d_eff_adr} >= DMEM_LIM);
  assign d_idx     = D_AW'(d_eff_adr);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      d_state_reg <= ST_IDLE;
      d_cnt_reg   <= 4'd0;
      d_adr_reg   <= 16'd0;
      d_dat_reg   <= 8'd0;
      d_we_reg    <= 1'b0;
      d_ack_reg   <= 1'b0;
      d_err_reg   <= 1'b0;
      d_rd_reg    <= 1'b0;
    end else begin
      d_state_reg <= d_state_next;
      d_cnt_reg   <= d_cnt_next;
      d_adr_reg   <= d_adr_next;
      d_dat_reg   <= d_dat_next;
      d_we_reg    <= d_we_next;
      d_ack_reg   <= d_go & ~d_oor;
      d_err_reg   <= d_go & d_oor;
      d_rd_reg    <= d_go & ~d_oor & ~d_eff_we;
    end
  end

  // The write lands on the edge entering RESP, so the next access sees it.
  always_ff @(posedge wb_clk_i) begin
    if (d_go & ~d_oor & d_eff_we) begin
      dmem[d_idx] <= d_eff_dat;
    end
    if (d_go & ~d_eff_we) begin
      d_q_reg <= dmem[d_idx];
    end
  end

  assign bus.wbd_dat_o = d_rd_reg ? d_q_reg : 8'h00;
  assign bus.wbd_ack_o = d_ack_reg;
  assign bus.wbd_err_o = d_err_reg;

endmodule
